// File: rtl/nes_dbg_ctrl.sv
// nes_dbg_ctrl: host-debug command controller in front of the CPU block.
// Pulls command bytes from a FWFT UART RX FIFO, halts/runs the CPU, reads
// debug registers and borrows the CPU memory bus for host reads (and writes),
// and pushes reply bytes into the UART TX FIFO.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_data/rx_empty    RX FIFO head byte / empty flag
//   rx_rd               registered 1-cycle pop; the byte is latched that cycle
//   tx_full/tx_data     TX FIFO full flag / reply byte
//   tx_wr               push, only ever high while tx_full = 0
//   cpu_brk             debug-break pulse, forces halted
//   cpu_dbgreg_out/sel  CPU debug register readback / select
//   cpu_ready           0 stalls the CPU (halted or bus borrowed)
//   mem_en/mem_a/mem_r_nw/mem_dout/mem_din  debug side of the CPU memory bus
//
// Optional build macro: NES_DBG_MEM_WR_EN adds opcode 0x06 MEM_WR.
module nes_dbg_ctrl #(
  parameter logic [23:0] CMD_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rx_rd,
  input  logic        tx_full,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        cpu_brk,
  input  logic [7:0]  cpu_dbgreg_out,
  output logic [3:0]  cpu_dbgreg_sel,
  output logic        cpu_ready,
  output logic        mem_en,
  output logic [15:0] mem_a,
  output logic        mem_r_nw,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din
);

  localparam logic [7:0] OP_ECHO   = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_QUERY  = 8'h03;
  localparam logic [7:0] OP_REG_RD = 8'h04;
  localparam logic [7:0] OP_MEM_RD = 8'h05;
`ifdef NES_DBG_MEM_WR_EN
  localparam logic [7:0] OP_MEM_WR = 8'h06;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ARG, S_ECHO, S_REG, S_MEM_SETTLE, S_MEM_RD, S_TX, S_MEM_DONE, S_MEM_WR
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  op, op_nx;
  logic [1:0]  argn, argn_nx;
  logic [8:0]  cnt, cnt_nx;
  logic        wcnt, wcnt_nx;
  logic [23:0] tmo, tmo_nx;
  logic        halted, halted_nx;
  logic        mem_req, mem_req_nx;
  logic        mem_en_nx, rx_rd_nx;
  logic [15:0] mem_a_nx;
  logic [7:0]  mem_dout_nx, tx_data_nx;
  logic [3:0]  sel_nx;
  logic        want, waiting, abort;
`ifdef NES_DBG_MEM_WR_EN
  logic        wr, wr_nx;   // write strobe cycle in progress
  assign mem_r_nw = !wr;
`else
  assign mem_r_nw = 1'b1;
`endif

  assign cpu_ready = !halted && !mem_en && !mem_req;
  assign tx_wr     = (state == S_TX) && !tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op             <= 8'h00;
      argn           <= 2'd0;
      cnt            <= 9'd0;
      wcnt           <= 1'b0;
      tmo            <= 24'd0;
      halted         <= 1'b1;
      mem_req        <= 1'b0;
      mem_en         <= 1'b0;
      mem_a          <= 16'h0000;
      mem_dout       <= 8'h00;
      tx_data        <= 8'h00;
      cpu_dbgreg_sel <= 4'h0;
      rx_rd          <= 1'b0;
`ifdef NES_DBG_MEM_WR_EN
      wr             <= 1'b0;
`endif
    end else begin
      state          <= state_nx;
      op             <= op_nx;
      argn           <= argn_nx;
      cnt            <= cnt_nx;
      wcnt           <= wcnt_nx;
      tmo            <= tmo_nx;
      halted         <= halted_nx;
      mem_req        <= mem_req_nx;
      mem_en         <= mem_en_nx;
      mem_a          <= mem_a_nx;
      mem_dout       <= mem_dout_nx;
      tx_data        <= tx_data_nx;
      cpu_dbgreg_sel <= sel_nx;
      rx_rd          <= rx_rd_nx;
`ifdef NES_DBG_MEM_WR_EN
      wr             <= wr_nx;
`endif
    end
  end

  // A byte is requested one cycle ahead (rx_rd registered) and consumed in the
  // cycle rx_rd is high, so every "if (rx_rd)" below means "rx_data is ours".
  always_comb begin
    state_nx    = state;
    op_nx       = op;
    argn_nx     = argn;
    cnt_nx      = cnt;
    wcnt_nx     = wcnt;
    tmo_nx      = tmo;
    halted_nx   = halted;
    mem_req_nx  = mem_req;
    mem_en_nx   = mem_en;
    mem_a_nx    = mem_a;
    mem_dout_nx = mem_dout;
    tx_data_nx  = tx_data;
    sel_nx      = cpu_dbgreg_sel;
    want        = 1'b0;
    abort       = 1'b0;
`ifdef NES_DBG_MEM_WR_EN
    wr_nx       = wr;
`endif
    case (state)
      S_IDLE: begin
        want = 1'b1;
        if (rx_rd) begin
          op_nx   = rx_data;
          argn_nx = 2'd0;
          case (rx_data)
`ifdef NES_DBG_MEM_WR_EN
            OP_MEM_WR,
`endif
            OP_ECHO, OP_REG_RD, OP_MEM_RD: state_nx = S_ARG;
            OP_HALT:  halted_nx = 1'b1;
            OP_RUN:   halted_nx = 1'b0;
            OP_QUERY: begin
              tx_data_nx = {7'd0, halted};
              state_nx   = S_TX;
            end
            default: ;
          endcase
        end
      end
      S_ARG: begin
        want = 1'b1;
        if (rx_rd) begin
          if (op == OP_ECHO) begin
            cnt_nx   = {1'b0, rx_data};
            state_nx = (rx_data == 8'h00) ? S_IDLE : S_ECHO;
          end else if (op == OP_REG_RD) begin
            sel_nx   = rx_data[3:0];
            wcnt_nx  = 1'b0;
            state_nx = S_REG;
          end else begin
            // memory ops: al, ah, n
            case (argn)
              2'd0: begin mem_a_nx[7:0]  = rx_data; argn_nx = 2'd1; end
              2'd1: begin mem_a_nx[15:8] = rx_data; argn_nx = 2'd2; end
              default: begin
                cnt_nx     = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                mem_req_nx = 1'b1;
                wcnt_nx    = 1'b0;
                state_nx   = S_MEM_SETTLE;
              end
            endcase
          end
        end
      end
      S_ECHO: begin
        want = 1'b1;
        if (rx_rd) begin
          tx_data_nx = rx_data;
          state_nx   = S_TX;
        end
      end
      S_REG: begin
        // one cycle for the new select to reach cpu_dbgreg_out
        if (!wcnt) wcnt_nx = 1'b1;
        else begin
          tx_data_nx = cpu_dbgreg_out;
          state_nx   = S_TX;
        end
      end
      S_MEM_SETTLE: begin
        // cpu_ready already low; give the CPU's ready latch two cycles
        if (!wcnt) wcnt_nx = 1'b1;
        else begin
          mem_en_nx = 1'b1;
          wcnt_nx   = 1'b0;
`ifdef NES_DBG_MEM_WR_EN
          state_nx  = (op == OP_MEM_WR) ? S_MEM_WR : S_MEM_RD;
`else
          state_nx  = S_MEM_RD;
`endif
        end
      end
      S_MEM_RD: begin
        if (!wcnt) wcnt_nx = 1'b1;
        else begin
          tx_data_nx = mem_din;
          state_nx   = S_TX;
        end
      end
      S_TX: begin
        if (!tx_full) begin
          if (op == OP_ECHO) begin
            cnt_nx   = cnt - 9'd1;
            state_nx = (cnt == 9'd1) ? S_IDLE : S_ECHO;
          end else if (op == OP_MEM_RD) begin
            mem_a_nx = mem_a + 16'd1;
            cnt_nx   = cnt - 9'd1;
            wcnt_nx  = 1'b0;
            state_nx = (cnt == 9'd1) ? S_MEM_DONE : S_MEM_RD;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_MEM_DONE: begin
        mem_en_nx  = 1'b0;
        mem_req_nx = 1'b0;
        state_nx   = S_IDLE;
      end
`ifdef NES_DBG_MEM_WR_EN
      S_MEM_WR: begin
        if (wr) begin
          // strobe cycle done: step to the next address
          wr_nx    = 1'b0;
          mem_a_nx = mem_a + 16'd1;
          cnt_nx   = cnt - 9'd1;
          if (cnt == 9'd1) state_nx = S_MEM_DONE;
        end else begin
          want = 1'b1;
          if (rx_rd) begin
            mem_dout_nx = rx_data;
            wr_nx       = 1'b1;
          end
        end
      end
`endif
      default: state_nx = S_IDLE;
    endcase

    // inter-byte timeout while a command is still arriving
    waiting = (state == S_ARG) || (state == S_ECHO) || (state == S_MEM_WR);
    if (rx_rd || !waiting) tmo_nx = 24'd0;
    else if (tmo == CMD_TIMEOUT - 24'd1) abort = 1'b1;
    else tmo_nx = tmo + 24'd1;
    if (abort) begin
      state_nx   = S_IDLE;
      mem_req_nx = 1'b0;
      mem_en_nx  = 1'b0;
      tmo_nx     = 24'd0;
`ifdef NES_DBG_MEM_WR_EN
      wr_nx      = 1'b0;
`endif
    end

    if (cpu_brk) halted_nx = 1'b1;
    // never back-to-back pops: the previous pop must land first
    rx_rd_nx = want && !rx_empty && !rx_rd && !abort;
  end

endmodule

// File: doc/nes_dbg_ctrl.md
Name: nes_dbg_ctrl

Overview:
- Host-debug command controller that sits directly upstream of the CPU block.
- Consumes command bytes from the UART RX FIFO and drives the CPU's ready and debug-register select inputs.
- Takes over the CPU-side memory bus for host reads/writes and returns replies through the UART TX FIFO.
- The top level muxes the debug address/data onto the CPU bus while mem_en is high.

Parameters:
- CMD_TIMEOUT, 24'hFFFFFF, idle cycles between bytes of one command before the command is aborted and the FSM returns to S_IDLE.

Ports:
- clk  in  1  50MHz system clock; one clock domain
- rst  in  1  reset; synchronous, active-high
- rx_data  in  8  RX FIFO head byte (first-word-fall-through)
- rx_empty  in  1  RX FIFO empty
- rx_rd  out  1  pop RX FIFO head (1-cycle pulse)
- tx_full  in  1  TX FIFO full
- tx_data  out  8  byte to TX FIFO
- tx_wr  out  1  push tx_data (1-cycle pulse)
- cpu_brk  in  1  CPU debug-break pulse
- cpu_dbgreg_out  in  8  CPU debug register read value
- cpu_dbgreg_sel  out  4  CPU debug register select
- cpu_ready  out  1  CPU ready (0 = CPU stalled)
- mem_en  out  1  debug owns CPU memory bus
- mem_a  out  16  debug memory address
- mem_r_nw  out  1  1 = read, 0 = write
- mem_dout  out  8  write data
- mem_din  in  8  read data, valid 1 cycle after mem_a is presented

Behaviour:
- Reset values:
  - halted = 1, so cpu_ready = 0; the CPU is held after reset until the host sends CPU_RUN.
  - rx_rd = 0, tx_wr = 0, tx_data = 0, cpu_dbgreg_sel = 0, mem_en = 0, mem_a = 0, mem_r_nw = 1, mem_dout = 0.
  - FSM in S_IDLE.
- cpu_ready = !halted && !mem_en && !mem_req.
- cpu_brk = 1 sets halted the same clock; if it coincides with a CPU_RUN decode, brk wins.
- RX handshake:
  - A byte is consumed only when rx_empty = 0.
  - rx_rd pulses for 1 cycle in the cycle the byte is latched; never two consecutive pulses.
- TX handshake:
  - tx_wr asserts only when tx_full = 0.
  - The FSM stalls in its reply state while tx_full = 1.
- FSM states:
  - S_IDLE: on byte, decode opcode.
  - S_ARG: collect 1–3 argument bytes per opcode.
  - S_ECHO: forward N bytes.
  - S_REG: set cpu_dbgreg_sel, wait 1 cycle, send cpu_dbgreg_out.
  - S_MEM_SETTLE: mem_req = 1 drops cpu_ready; wait 2 cycles (CPU ready latch delay), then assert mem_en.
  - S_MEM_RD: present mem_a, wait 1 cycle, capture mem_din, go to S_TX.
  - S_TX: send byte, increment address, decrement count.
  - S_MEM_DONE: deassert mem_en and return to S_IDLE.
- Opcodes:
  - 0x00 ECHO n, b0..b(n-1): echo n bytes; n = 0 sends nothing.
  - 0x01 CPU_HALT: halted = 1; no reply.
  - 0x02 CPU_RUN: halted = 0; no reply.
  - 0x03 QUERY_HLT: reply 0x01 if halted, else 0x00.
  - 0x04 REG_RD sel: cpu_dbgreg_sel = sel[3:0]; reply 1 byte.
  - 0x05 MEM_RD al, ah, n: read n bytes starting at {ah,al}; n = 0 means 256 bytes.
  - Any other opcode is dropped silently; the FSM stays in S_IDLE.
- MEM address increments mod 2^16 (0xFFFF wraps to 0x0000). The count is an 9-bit internal counter.
- Memory ops work whether halted or running. If running, the CPU is stalled only for the duration and resumes with halted unchanged.
- Timeout: a counter resets on every consumed byte. In S_ARG/S_ECHO with no byte for CMD_TIMEOUT cycles, return to S_IDLE, clear mem_req/mem_en, and send no partial reply.
- rst mid-operation: immediate return to reset values; any in-progress reply is truncated.

Optional Feature:
- Macro: NES_DBG_MEM_WR_EN.
- When defined, adds opcode 0x06 MEM_WR al, ah, n, d0..d(n-1) (n = 0 means 256 bytes).
  - Each data byte is driven on mem_dout with mem_r_nw = 0 for exactly 1 cycle at the current address, then the address increments.
  - No reply is sent.
  - Timeout applies between data bytes.
- When not defined, 0x06 is treated as an unknown opcode and dropped; mem_r_nw is tied to 1.

Test Plan:
- Reset released, then QUERY_HLT (0x03) → cpu_ready = 0, TX 0x01. Send 0x02 then 0x03 → cpu_ready = 1, TX 0x00.
- ECHO 0x00,0x03,0xAA,0x55,0x7E with tx_full held high for 10 cycles mid-stream → TX exactly AA 55 7E, no drops or duplicates, each rx_rd a single pulse.
- CPU running, MEM_RD 0x05,0xFE,0xFF,0x03 with memory[i] = i[7:0] → cpu_ready drops ≥2 cycles before mem_en; mem_a = FFFE, FFFF, 0000; TX FE FF 00; cpu_ready returns to 1 afterwards.
- cpu_brk pulse in the same cycle CPU_RUN is decoded → halted = 1, cpu_ready stays 0.
- REG_RD 0x04,0x01 with cpu_dbgreg_out = 0x80 while sel = 1 → cpu_dbgreg_sel = 1, TX 0x80.
- MEM_RD 0x05,0x00 then no further bytes for CMD_TIMEOUT cycles (parameter set to 100) → FSM back in S_IDLE, no TX, mem_en = 0. With NES_DBG_MEM_WR_EN defined: 0x06,0x00,0x02,0x02,0x11,0x22 → writes 0x11@0x0200 and 0x22@0x0201.
